// File: rtl/event_counter_pkg.sv
// Shared definitions for the event counter array: serializer states and parameter limits.
`timescale 1ns/1ps
package event_counter_pkg;

  localparam int NUM_CH_MAX = 8;
  localparam int CNT_W_MAX  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/ch_counter.sv
// One event channel: 2-FF synchroniser, registered rising-edge detect, counter and sticky overflow.
// Build macro COUNTER_SATURATE_EN: defined -> counter holds at all-ones, undefined -> counter wraps.
`timescale 1ns/1ps
module ch_counter
  import event_counter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pin,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             ovf_evt
);

  if (CNT_W < 4 || CNT_W > CNT_W_MAX) begin : g_bad_width
    $error("ch_counter: CNT_W out of range");
  end

  logic sync_1, sync_2, sync_3;
  logic pulse;
  logic cnt_full;

  // The edge detector keeps tracking while disabled so re-enabling never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign pulse    = sync_2 & ~sync_3;
  assign cnt_full = &cnt;
  assign ovf_evt  = ena & pulse & cnt_full & ~snap;

  // A snapshot opens a new window; an edge in that same cycle belongs to the new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (ena) begin
      if (snap) begin
        cnt <= pulse ? CNT_W'(1) : '0;
        ovf <= 1'b0;
      end else if (pulse) begin
        if (cnt_full) begin
          ovf <= 1'b1;
`ifdef COUNTER_SATURATE_EN
          cnt <= cnt;
`else
          cnt <= '0;
`endif
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/event_counter_array.sv
// Multi-channel event counter: RTC-closed windows, snapshot, MSB-first serial readout, sticky flags.
// Build macro COUNTER_SATURATE_EN selects saturating counters (see ch_counter).
`timescale 1ns/1ps
module event_counter_array
  import event_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic              rtc_in,
  input  logic              clr_flags,
  output logic              serial_out,
  output logic              sl_out,
  output logic [ADDR_W-1:0] ch_addr,
  output logic              ovf_ch_out,
  output logic              ovf_global,
  output logic              ovf_rtc_out,
  output logic              busy
);

  localparam int BIT_W = $clog2(CNT_W);

  if (NUM_CH < 2 || NUM_CH > NUM_CH_MAX || (1 << ADDR_W) < NUM_CH) begin : g_bad_cfg
    $error("event_counter_array: NUM_CH/ADDR_W out of range");
  end

  logic              rtc_s1, rtc_s2, rtc_s3;
  logic              rtc_pulse;
  logic              snap;
  logic              rtc_collide;
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] ovf_evt;
  logic [NUM_CH-1:0] shovf;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ch_idx, ch_idx_next;
  logic [BIT_W-1:0]  bit_idx, bit_idx_next;
  logic [BIT_W-1:0]  cur_bit;
  logic [CNT_W-1:0]  sel_word;
  logic              sel_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtc_s1 <= 1'b0;
      rtc_s2 <= 1'b0;
      rtc_s3 <= 1'b0;
    end else begin
      rtc_s1 <= rtc_in;
      rtc_s2 <= rtc_s1;
      rtc_s3 <= rtc_s2;
    end
  end

  assign rtc_pulse   = rtc_s2 & ~rtc_s3;
  // A tick during a frame is dropped (window extends) and only flagged.
  assign snap        = ena & rtc_pulse & (state == IDLE);
  assign rtc_collide = ena & rtc_pulse & (state != IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_counter #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .pin     (ch_in[g]),
      .snap    (snap),
      .cnt     (cnt[g]),
      .ovf     (ovf[g]),
      .ovf_evt (ovf_evt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      shovf <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= cnt[i];
      shovf <= ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch_idx  <= '0;
      bit_idx <= '0;
    end else if (ena) begin
      state   <= state_next;
      ch_idx  <= ch_idx_next;
      bit_idx <= bit_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    ch_idx_next  = ch_idx;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (snap) begin
          state_next  = LOAD;
          ch_idx_next = '0;
        end
      end
      LOAD: begin
        state_next   = SHIFT;
        bit_idx_next = BIT_W'(CNT_W - 2);
      end
      SHIFT: begin
        if (bit_idx == '0) begin
          if (ch_idx == ADDR_W'(NUM_CH - 1)) begin
            state_next  = IDLE;
            ch_idx_next = '0;
          end else begin
            state_next  = LOAD;
            ch_idx_next = ch_idx + ADDR_W'(1);
          end
        end else begin
          bit_idx_next = bit_idx - BIT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel mux written as a compare loop so ch_addr may be wider than the channel index.
  always_comb begin
    sel_word = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == ADDR_W'(i)) begin
        sel_word = shadow[i];
        sel_ovf  = shovf[i];
      end
    end
  end

  assign cur_bit    = (state == LOAD) ? BIT_W'(CNT_W - 1) : bit_idx;
  assign busy       = (state != IDLE);
  assign sl_out     = (state == LOAD);
  assign ch_addr    = busy ? ch_idx : '0;
  assign serial_out = busy & sel_word[cur_bit];
  assign ovf_ch_out = busy & sel_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_global  <= 1'b0;
      ovf_rtc_out <= 1'b0;
    end else begin
      if (|ovf_evt)       ovf_global <= 1'b1;
      else if (clr_flags) ovf_global <= 1'b0;
      if (rtc_collide)    ovf_rtc_out <= 1'b1;
      else if (clr_flags) ovf_rtc_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_counter_array.sv
// Directed bench for event_counter_array: a reference count model feeds an expected-frame queue.
`timescale 1ns/1ps
module tb_event_counter_array;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 3;
  localparam int W      = ADDR_W + 4;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [NUM_CH-1:0] ch_in;
  logic              rtc_in;
  logic              clr_flags;
  logic              serial_out;
  logic              sl_out;
  logic [ADDR_W-1:0] ch_addr;
  logic              ovf_ch_out;
  logic              ovf_global;
  logic              ovf_rtc_out;
  logic              busy;

  event_counter_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .ch_in       (ch_in),
    .rtc_in      (rtc_in),
    .clr_flags   (clr_flags),
    .serial_out  (serial_out),
    .sl_out      (sl_out),
    .ch_addr     (ch_addr),
    .ovf_ch_out  (ovf_ch_out),
    .ovf_global  (ovf_global),
    .ovf_rtc_out (ovf_rtc_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-slot expectation: {busy, sl_out, ch_addr, ovf_ch_out, serial_out}
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] m_cnt [NUM_CH];
  logic             m_ovf [NUM_CH];
  logic             m_glob;
  logic             m_rtc;
  int               n_assert;
  int               n_fail;

  function automatic logic [W-1:0] obs_vec();
    return {busy, sl_out, ch_addr, ovf_ch_out, serial_out};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ovf_global"}, W'(ovf_global), W'(m_glob));
    chk({tag, "_ovf_rtc"}, W'(ovf_rtc_out), W'(m_rtc));
  endtask

  task automatic model_edge(input int ch);
    if (m_cnt[ch] == {CNT_W{1'b1}}) begin
      m_ovf[ch] = 1'b1;
      m_glob    = 1'b1;
`ifndef COUNTER_SATURATE_EN
      m_cnt[ch] = '0;
`endif
    end else begin
      m_cnt[ch] = m_cnt[ch] + CNT_W'(1);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k] = '0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < NUM_CH; k++)
      for (int b = CNT_W - 1; b >= 0; b--)
        exp_q.push_back({1'b1, (b == CNT_W - 1), ADDR_W'(k), m_ovf[k], m_cnt[k][b]});
  endtask

  task automatic pulse_ch(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      ch_in[ch] = 1'b1;
      repeat (2) @(negedge clk);
      ch_in[ch] = 1'b0;
      repeat (2) @(negedge clk);
      model_edge(ch);
    end
  endtask

  // Tick from IDLE: the model snapshots now; optional channel edge lands in the same cycle.
  task automatic drive_rtc(input bit push, input int ch_also);
    rtc_in = 1'b1;
    if (ch_also >= 0) ch_in[ch_also] = 1'b1;
    if (push) push_frame();
    model_clear();
    if (ch_also >= 0) model_edge(ch_also);
    repeat (2) @(negedge clk);
    rtc_in = 1'b0;
    if (ch_also >= 0) ch_in[ch_also] = 1'b0;
  endtask

  task automatic wait_busy(input string tag, output bit got);
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_start"}, W'(got), W'(1));
  endtask

  task automatic check_frame(input string tag);
    bit got;
    logic [W-1:0] e;
    wait_busy(tag, got);
    if (got) begin
      for (int n = 0; n < NUM_CH * CNT_W; n++) begin
        if (n > 0) @(negedge clk);
        e = exp_q.pop_front();
        chk($sformatf("%s_slot%0d", tag, n), obs_vec(), e);
      end
      @(negedge clk);
      chk({tag, "_end"}, obs_vec(), '0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    bit got;
    n_assert  = 0;
    n_fail    = 0;
    m_glob    = 1'b0;
    m_rtc     = 1'b0;
    model_clear();
    rst_n     = 1'b0;
    ena       = 1'b1;
    ch_in     = '0;
    rtc_in    = 1'b0;
    clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", obs_vec(), '0);
    chk_flags("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", obs_vec(), '0);

    // Basic frame
    pulse_ch(0, 5);
    pulse_ch(2, 3);
    drive_rtc(1'b1, -1);
    check_frame("s1");
    chk_flags("s1");

    // Pin rises while disabled: must not produce a count later
    ena = 1'b0;
    ch_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("ena_off_idle", obs_vec(), '0);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    ch_in[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Overflow on ch1
    pulse_ch(1, 257);
    chk_flags("s2_pre");
    drive_rtc(1'b1, -1);
    check_frame("s2");

    // Tick during a frame
    pulse_ch(3, 4);
    drive_rtc(1'b1, -1);
    fork
      check_frame("s3a");
      begin
        repeat (6) @(negedge clk);
        rtc_in = 1'b1;
        repeat (2) @(negedge clk);
        rtc_in = 1'b0;
        repeat (2) @(negedge clk);
        m_rtc = 1'b1;
        pulse_ch(0, 2);
      end
    join
    chk_flags("s3_post");
    pulse_ch(2, 1);
    drive_rtc(1'b1, -1);
    check_frame("s3b");

    // Flag clear
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    m_glob = 1'b0;
    m_rtc  = 1'b0;
    chk_flags("s6_clr");

    // Channel edge coincident with snapshot
    drive_rtc(1'b1, 3);
    check_frame("s4a");
    drive_rtc(1'b1, -1);
    check_frame("s4b");

    // Reset in the middle of a frame
    pulse_ch(0, 3);
    drive_rtc(1'b0, -1);
    wait_busy("s5_abort", got);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    m_glob = 1'b0;
    m_rtc  = 1'b0;
    chk("s5_rst_outputs", obs_vec(), '0);
    chk_flags("s5_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive_rtc(1'b1, -1);
    check_frame("s5");
    chk_flags("s5_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
